inst_buffer_param: RTL and testbench
====================================

Name: inst_buffer_param

Overview:
- Parametrised decoupling FIFO between decode and rename, replacing the fixed 8-in/4-out instruction buffer.
- Accepts up to FETCH_W decoded packets per cycle under any valid-bit pattern and compacts them in slot order.
- Dispatches a group of up to DISP_W packets per cycle. The effective dispatch width is set at run time by disp_width_i for width-adaptive cores.
- Also reports branch count per dispatched group and buffer occupancy.

Parameters:
- DEPTH, 32, entries; power of two, >= 2*FETCH_W
- DEPTH_LOG, 5, log2(DEPTH)
- FETCH_W, 8, write lanes per cycle
- DISP_W, 4, read lanes per cycle; DISP_W <= FETCH_W
- WLOG, 3, bits for disp_width_i, enough to hold DISP_W
- PKT_W, 96, decoded packet width
- BR_BIT, 70, bit index of the branch flag inside a packet

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush on control mispredict
- stall_i  in  1  back-end cannot accept a group this cycle
- wr_valid_i  in  FETCH_W  per-lane valid for incoming packets
- wr_data_i  in  FETCH_W*PKT_W  lane i at bits [i*PKT_W +: PKT_W]
- wr_ready_o  out  1  free entries >= FETCH_W; low acts as fetch stall
- disp_width_i  in  WLOG  run-time dispatch width, 0..DISP_W
- rd_valid_o  out  DISP_W  lane k holds a dispatched packet this cycle
- rd_data_o  out  DISP_W*PKT_W  packets from head, lane 0 oldest
- branch_count_o  out  WLOG+1  count of BR_BIT set over valid read lanes
- count_o  out  DEPTH_LOG+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and count clear to 0.
  - rd_valid_o=0, rd_data_o=0, branch_count_o=0, count_o=0, wr_ready_o=1.
  - Storage contents are don't-care.
- Effective width W:
  - W = min(disp_width_i, DISP_W).
  - W=0 means no dispatch.
  - A change in disp_width_i takes effect the same cycle; no entry is lost or duplicated.
- Enqueue:
  - Occurs when wr_ready_o=1 and not flush_i.
  - n_in = popcount(wr_valid_i).
  - The j-th set valid lane, counting from lane 0, writes entry (tail+j) mod DEPTH.
  - tail advances by n_in.
  - When wr_ready_o=0 all lanes are dropped; the upstream must hold its data.
- Read side:
  - Combinational from registered storage; lane k reads entry (head+k) mod DEPTH.
  - Write-to-read latency is 1 cycle, with no same-cycle bypass.
- Dispatch (baseline, all-or-nothing):
  - group_ok = (count >= W) and W != 0.
  - When group_ok: rd_valid_o[k]=1 for k<W.
  - Lanes k>=W: rd_valid_o=0, rd_data lane forced to zero.
  - When group_ok=0: all rd_valid_o=0, all data lanes zero.
- Dequeue:
  - Occurs when group_ok and not stall_i; head advances by W (mod DEPTH).
  - Outputs are still presented while stall_i=1; only the pointer holds.
- Occupancy:
  - count_next = count + n_in - n_out, computed in DEPTH_LOG+1 bits. Simultaneous enqueue and dequeue are legal.
  - count never exceeds DEPTH, because wr_ready_o guarantees FETCH_W free entries.
- Branch count:
  - branch_count_o = sum over k of rd_valid_o[k] AND lane k packet bit BR_BIT.
  - Combinational, and valid even while stall_i=1.
- Flush:
  - Next edge: head=tail=count=0.
  - Any enqueue or dequeue in the flush cycle is discarded.
  - Flush has priority over all other updates.
- Wrap-around: pointers are DEPTH_LOG bits and wrap naturally; a group may straddle entry DEPTH-1 to 0.
- Full/empty:
  - Empty: count=0, so rd_valid_o=0.
  - Near-full: DEPTH-count < FETCH_W, so wr_ready_o=0 even when fewer lanes are valid.

Optional Feature:
- Macro: INST_BUFFER_PARTIAL_DISPATCH_EN
- Defined:
  - When 0 < count < W, dispatches n_out = count packets.
  - rd_valid_o[k]=1 for k<count; head advances by count.
  - Reduces drain latency at the tail of a fetch block.
- Undefined: strict all-or-nothing rule as above; n_out is W or 0.

Test Plan:
1. Reset mid-traffic: count=10, drop reset to 0 -> outputs 0 immediately (before next edge), wr_ready_o=1; after release, first write appears one cycle later.
2. Sparse write: wr_valid_i=8'b1010_0101 with lanes tagged 0..7, W=4 -> after 1 cycle rd_valid_o=4'b1111, data in order lanes 0,2,5,7, count_o=4.
3. Wrap/straddle: DEPTH=32, head=tail=30 via prior traffic, write 8, W=4, stall_i=0 -> dispatches entries 30,31,0,1, then 2..5; count returns to 0.
4. Full boundary: count=25, FETCH_W=8 -> wr_ready_o=0, writes ignored. After one dispatch of 4, count=21 -> wr_ready_o=1.
5. Width change plus branches: count=3, W=4 -> no dispatch (no macro). Switch disp_width_i to 2 with branch flags on entries 0,1 -> rd_valid_o=4'b0011, branch_count_o=2, count 3->1. With the macro, W=4 and count=3 -> 3 lanes dispatched.
6. Flush plus stall: stall_i=1 and simultaneous 8-lane write with flush_i=1 -> next cycle count=0, rd_valid_o=0, wr_ready_o=1.

Source files
------------

// File: rtl/inst_buffer_param_if.sv
// rtl/inst_buffer_param_if.sv - fetch/dispatch bus bundle for inst_buffer_param
interface inst_buffer_param_if #(
  parameter int FETCH_W   = 8,
  parameter int DISP_W    = 4,
  parameter int WLOG      = 3,
  parameter int PKT_W     = 96,
  parameter int DEPTH_LOG = 5
);
  logic                       flush_i;
  logic                       stall_i;
  logic [FETCH_W-1:0]         wr_valid_i;
  logic [FETCH_W*PKT_W-1:0]   wr_data_i;
  logic                       wr_ready_o;
  logic [WLOG-1:0]            disp_width_i;
  logic [DISP_W-1:0]          rd_valid_o;
  logic [DISP_W*PKT_W-1:0]    rd_data_o;
  logic [WLOG:0]              branch_count_o;
  logic [DEPTH_LOG:0]         count_o;

  modport slave (
    input  flush_i, stall_i, wr_valid_i, wr_data_i, disp_width_i,
    output wr_ready_o, rd_valid_o, rd_data_o, branch_count_o, count_o
  );

  modport master (
    output flush_i, stall_i, wr_valid_i, wr_data_i, disp_width_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, branch_count_o, count_o
  );
endinterface

// File: rtl/inst_buffer_param.sv
// rtl/inst_buffer_param.sv - compacting decode-to-rename instruction FIFO with run-time dispatch width
// Optional macro INST_BUFFER_PARTIAL_DISPATCH_EN lets a short group (0 < count < W) dispatch.
module inst_buffer_param #(
  parameter int DEPTH     = 32,
  parameter int DEPTH_LOG = 5,
  parameter int FETCH_W   = 8,
  parameter int DISP_W    = 4,
  parameter int WLOG      = 3,
  parameter int PKT_W     = 96,
  parameter int BR_BIT    = 70
) (
  input logic clk,
  input logic reset,
  inst_buffer_param_if.slave bus
);
  localparam int CW = DEPTH_LOG + 1;
  localparam int BW = WLOG + 1;

  logic [PKT_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_head;
  logic [DEPTH_LOG-1:0] r_tail;
  logic [CW-1:0]        r_count;

  logic [CW-1:0]        w_n_in;
  logic [CW-1:0]        w_n_out;
  logic [CW-1:0]        w_width;
  logic [CW-1:0]        w_free;
  logic [DEPTH_LOG-1:0] w_off [FETCH_W];
  logic                 w_wr_ready;
  logic                 w_enq;
  logic                 w_deq;
  logic [DISP_W-1:0]    w_rd_valid;
  logic [DISP_W*PKT_W-1:0] w_rd_data;
  logic [BW-1:0]        w_br_cnt;

  // Running popcount gives each valid lane its compacted slot offset.
  always_comb begin
    w_n_in = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_off[i] = w_n_in[DEPTH_LOG-1:0];
      w_n_in   = w_n_in + CW'(bus.wr_valid_i[i]);
    end
  end

  always_comb begin
    if (bus.disp_width_i > WLOG'(DISP_W)) w_width = CW'(DISP_W);
    else                                  w_width = CW'(bus.disp_width_i);
  end

  always_comb begin
    w_n_out = '0;
    if (w_width != '0) begin
      if (r_count >= w_width) w_n_out = w_width;
`ifdef INST_BUFFER_PARTIAL_DISPATCH_EN
      else                    w_n_out = r_count;
`endif
    end
  end

  assign w_free     = CW'(DEPTH) - r_count;
  assign w_wr_ready = (w_free >= CW'(FETCH_W));
  assign w_enq      = w_wr_ready && !bus.flush_i;
  assign w_deq      = (w_n_out != '0) && !bus.stall_i && !bus.flush_i;

  always_comb begin
    w_rd_valid = '0;
    w_rd_data  = '0;
    w_br_cnt   = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (CW'(k) < w_n_out) begin
        w_rd_valid[k]              = 1'b1;
        w_rd_data[k*PKT_W +: PKT_W] = r_mem[r_head + DEPTH_LOG'(k)];
        w_br_cnt                   = w_br_cnt + BW'(r_mem[r_head + DEPTH_LOG'(k)][BR_BIT]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (bus.wr_valid_i[i]) r_mem[r_tail + w_off[i]] <= bus.wr_data_i[i*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + w_n_in[DEPTH_LOG-1:0];
      if (w_deq) r_head <= r_head + w_n_out[DEPTH_LOG-1:0];
      r_count <= r_count + (w_enq ? w_n_in : CW'(0)) - (w_deq ? w_n_out : CW'(0));
    end
  end

  assign bus.wr_ready_o     = w_wr_ready;
  assign bus.rd_valid_o     = w_rd_valid;
  assign bus.rd_data_o      = w_rd_data;
  assign bus.branch_count_o = w_br_cnt;
  assign bus.count_o        = r_count;
endmodule

// File: tb/tb_inst_buffer_param.sv
// tb/tb_inst_buffer_param.sv - directed table-driven bench for inst_buffer_param
module tb_inst_buffer_param;
  localparam int PKT_W = 96;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  inst_buffer_param_if bus ();
  inst_buffer_param dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       st;
    logic [7:0] wv;
    logic [7:0] tag0;
    logic [7:0] br;
    logic [2:0] dw;
    logic [3:0] rv;
    logic [3:0] bc;
    logic [5:0] cnt;
    logic       rdy;
    logic [31:0] tags;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t v(logic fl, logic st, logic [7:0] wv, logic [7:0] tag0, logic [7:0] br,
                             logic [2:0] dw, logic [3:0] rv, logic [3:0] bc, logic [5:0] cnt,
                             logic rdy, logic [31:0] tags);
    vec_t r;
    r.fl = fl; r.st = st; r.wv = wv; r.tag0 = tag0; r.br = br; r.dw = dw;
    r.rv = rv; r.bc = bc; r.cnt = cnt; r.rdy = rdy; r.tags = tags;
    return r;
  endfunction

  function automatic logic [PKT_W-1:0] pkt(logic [7:0] tag, logic br);
    logic [PKT_W-1:0] p;
    p         = '0;
    p[7:0]    = tag;
    p[95:88]  = 8'hA5;
    p[70]     = br;
    return p;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic fl, logic st, logic [7:0] wv, logic [7:0] tag0, logic [7:0] br,
                       logic [2:0] dw);
    bus.flush_i      = fl;
    bus.stall_i      = st;
    bus.wr_valid_i   = wv;
    bus.disp_width_i = dw;
    for (int i = 0; i < 8; i++) bus.wr_data_i[i*PKT_W +: PKT_W] = pkt(tag0 + 8'(i), br[i]);
  endtask

  task automatic chk_out(string tag, logic [3:0] rv, logic [3:0] bc, logic [5:0] cnt, logic rdy,
                         logic [31:0] tags);
    logic [PKT_W-1:0] lane;
    chk({tag, " rd_valid"}, 32'(bus.rd_valid_o), 32'(rv));
    chk({tag, " branch_count"}, 32'(bus.branch_count_o), 32'(bc));
    chk({tag, " count"}, 32'(bus.count_o), 32'(cnt));
    chk({tag, " wr_ready"}, 32'(bus.wr_ready_o), 32'(rdy));
    for (int k = 0; k < 4; k++) begin
      lane = bus.rd_data_o[k*PKT_W +: PKT_W];
      if (rv[k]) chk($sformatf("%s lane%0d tag", tag, k), {16'h0, lane[95:88], lane[7:0]},
                     {16'h0, 8'hA5, tags[k*8 +: 8]});
      else       chk($sformatf("%s lane%0d zero", tag, k), 32'(|lane), 32'd0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tbl[0]  = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b0000,0, 0,1,32'h0);
    tbl[1]  = v(0,0,8'hA5,8'h10,8'h00,3'd0,4'b0000,0, 0,1,32'h0);
    tbl[2]  = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b1111,0, 4,1,32'h17151210);
    tbl[3]  = v(0,0,8'hFF,8'h20,8'h06,3'd4,4'b0000,0, 0,1,32'h0);
    tbl[4]  = v(0,1,8'h00,8'h00,8'h00,3'd4,4'b1111,2, 8,1,32'h23222120);
    tbl[5]  = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b1111,2, 8,1,32'h23222120);
    tbl[6]  = v(0,0,8'h00,8'h00,8'h00,3'd2,4'b0011,0, 4,1,32'h00002524);
    tbl[7]  = v(0,0,8'h00,8'h00,8'h00,3'd7,4'b0000,0, 2,1,32'h0);
    tbl[8]  = v(0,0,8'h00,8'h00,8'h00,3'd2,4'b0011,0, 2,1,32'h00002726);
    tbl[9]  = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b0000,0, 0,1,32'h0);
    tbl[10] = v(0,0,8'hFF,8'h30,8'h00,3'd0,4'b0000,0, 0,1,32'h0);
    tbl[11] = v(0,0,8'hFF,8'h38,8'h00,3'd0,4'b0000,0, 8,1,32'h0);
    tbl[12] = v(0,0,8'hFF,8'h40,8'h30,3'd0,4'b0000,0,16,1,32'h0);
    tbl[13] = v(0,0,8'h01,8'h50,8'h00,3'd0,4'b0000,0,24,1,32'h0);
    tbl[14] = v(0,0,8'hFF,8'h60,8'h00,3'd0,4'b0000,0,25,0,32'h0);
    tbl[15] = v(0,0,8'hFF,8'h60,8'h00,3'd4,4'b1111,0,25,0,32'h33323130);
    tbl[16] = v(0,0,8'h00,8'h00,8'h00,3'd0,4'b0000,0,21,1,32'h0);
    tbl[17] = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b1111,0,21,1,32'h37363534);
    tbl[18] = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b1111,0,17,1,32'h3B3A3938);
    tbl[19] = v(0,0,8'h00,8'h00,8'h00,3'd3,4'b0111,0,13,1,32'h003E3D3C);
    tbl[20] = v(0,0,8'h00,8'h00,8'h00,3'd7,4'b1111,0,10,1,32'h4241403F);
    tbl[21] = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b1111,2, 6,1,32'h46454443);
    tbl[22] = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b0000,0, 2,1,32'h0);
    tbl[23] = v(0,0,8'h00,8'h00,8'h00,3'd1,4'b0001,0, 2,1,32'h00000047);
    tbl[24] = v(0,0,8'h00,8'h00,8'h00,3'd1,4'b0001,0, 1,1,32'h00000050);
    tbl[25] = v(0,0,8'h07,8'h70,8'h03,3'd0,4'b0000,0, 0,1,32'h0);
`ifdef INST_BUFFER_PARTIAL_DISPATCH_EN
    tbl[26] = v(0,1,8'h00,8'h00,8'h00,3'd4,4'b0111,2, 3,1,32'h00727170);
`else
    tbl[26] = v(0,1,8'h00,8'h00,8'h00,3'd4,4'b0000,0, 3,1,32'h0);
`endif
    tbl[27] = v(0,0,8'h00,8'h00,8'h00,3'd2,4'b0011,2, 3,1,32'h00007170);
    tbl[28] = v(0,0,8'h00,8'h00,8'h00,3'd1,4'b0001,0, 1,1,32'h00000072);
    tbl[29] = v(0,0,8'hFF,8'h80,8'h00,3'd0,4'b0000,0, 0,1,32'h0);
    tbl[30] = v(1,1,8'hFF,8'h90,8'h00,3'd4,4'b1111,0, 8,1,32'h83828180);
    tbl[31] = v(0,0,8'h00,8'h00,8'h00,3'd4,4'b0000,0, 0,1,32'h0);
    tbl[32] = v(0,0,8'h03,8'hA0,8'h00,3'd0,4'b0000,0, 0,1,32'h0);
    tbl[33] = v(0,0,8'h00,8'h00,8'h00,3'd2,4'b0011,0, 2,1,32'h0000A1A0);

    reset = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 8'h00, 3'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 4'b0000, 0, 0, 1, 32'h0);
    reset = 1'b1;

    for (int r = 0; r < 34; r++) begin
      @(negedge clk);
      drive(tbl[r].fl, tbl[r].st, tbl[r].wv, tbl[r].tag0, tbl[r].br, tbl[r].dw);
      #1;
      chk_out($sformatf("row%0d", r), tbl[r].rv, tbl[r].bc, tbl[r].cnt, tbl[r].rdy, tbl[r].tags);
    end

    // Asynchronous reset with 10 entries queued, then first write after release.
    @(negedge clk);
    drive(0, 0, 8'hFF, 8'hC0, 8'h00, 3'd0);
    @(negedge clk);
    drive(0, 0, 8'h03, 8'hD0, 8'h00, 3'd0);
    @(negedge clk);
    drive(0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    #1;
    chk("midreset pre count", 32'(bus.count_o), 32'd10);
    bus.disp_width_i = 3'd4;
    #1;
    chk("midreset pre rd_valid", 32'(bus.rd_valid_o), 32'hF);
    reset = 1'b0;
    #1;
    chk_out("midreset", 4'b0000, 0, 0, 1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 8'h01, 8'hE0, 8'h00, 3'd0);
    #1;
    chk("postreset same-cycle count", 32'(bus.count_o), 32'd0);
    @(negedge clk);
    drive(0, 0, 8'h00, 8'h00, 8'h00, 3'd1);
    #1;
    chk_out("postreset", 4'b0001, 0, 1, 1, 32'h000000E0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
